// File: rtl/pbs_pkg.sv
// Shared definitions for the battle-system blocks: move table, FSM states, LFSR seed and taps.
package pbs_pkg;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Feedback from bits 8,6,5,4 (1-based) of the shift register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Indexed by move number: element [0] is move 0.
  localparam logic [3:0][3:0] MOVE_DMG = {4'd9, 4'd6, 4'd4, 4'd2};
  localparam logic [3:0][3:0] MOVE_ACC = {4'd3, 4'd7, 4'd11, 4'd15};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_ROLL    = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic [3:0] sat_double(input logic [3:0] v);
    logic [4:0] d;
    d = {v, 1'b0};
    return d[4] ? 4'hF : d[3:0];
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; shared random source for combat and AI logic.
module lfsr8
  import pbs_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] q
);

  // Shift every cycle; a nonzero seed keeps the sequence off the all-zero lockup state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/move_resolver.sv
// Resolves one attack: picks the move, rolls accuracy, reports hit/damage four cycles after start.
// Optional critical hits are enabled by defining CRIT_HIT_EN.
module move_resolver
  import pbs_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       attacker,
  input  logic [1:0] p_move,
  output logic       busy,
  output logic       done,
  output logic [1:0] move_used,
  output logic       hit,
  output logic [3:0] dmg,
  output logic       crit
);

  state_e      state_r, state_s;
  logic [7:0]  lfsr_q_s;
  logic        att_r;
  logic [1:0]  pmove_r;
  logic [1:0]  sel_r;
  logic [3:0]  roll_r;
  logic        busy_r, done_r, hit_r;
  logic [1:0]  move_used_r;
  logic [3:0]  dmg_r;
  logic        hit_s;
  logic [3:0]  dmg_s;
  logic        crit_s;

  lfsr8 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (lfsr_q_s)
  );

  // Next-state logic: every busy state lasts exactly one cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_SELECT;
        else       state_s = ST_IDLE;
      end
      ST_SELECT:  state_s = ST_ROLL;
      ST_ROLL:    state_s = ST_RESOLVE;
      ST_RESOLVE: state_s = ST_DONE;
      ST_DONE:    state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

`ifdef CRIT_HIT_EN
  logic [3:0] critroll_r;
  logic       crit_r;

  // Outcome of the latched roll; a max critroll on a hit doubles damage.
  always_comb begin
    hit_s  = (roll_r <= MOVE_ACC[sel_r]);
    crit_s = hit_s && (critroll_r == 4'hF);
    if (crit_s)     dmg_s = sat_double(MOVE_DMG[sel_r]);
    else if (hit_s) dmg_s = MOVE_DMG[sel_r];
    else            dmg_s = 4'd0;
  end

  // Critical-hit roll and flag, captured alongside the accuracy roll and results.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      critroll_r <= 4'd0;
      crit_r     <= 1'b0;
    end else begin
      if (state_r == ST_ROLL)    critroll_r <= lfsr_q_s[7:4];
      if (state_r == ST_RESOLVE) crit_r     <= crit_s;
    end
  end

  assign crit = crit_r;
`else
  logic unused_crit_bits_s;

  // Outcome of the latched roll.
  always_comb begin
    hit_s  = (roll_r <= MOVE_ACC[sel_r]);
    crit_s = 1'b0;
    if (hit_s) dmg_s = MOVE_DMG[sel_r];
    else       dmg_s = 4'd0;
  end

  assign unused_crit_bits_s = ^{lfsr_q_s[7:4], crit_s};
  assign crit               = 1'b0;
`endif

  // Sequencer and datapath; published results change only when a new attack resolves.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      att_r       <= 1'b0;
      pmove_r     <= 2'd0;
      sel_r       <= 2'd0;
      roll_r      <= 4'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      move_used_r <= 2'd0;
      hit_r       <= 1'b0;
      dmg_r       <= 4'd0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            att_r   <= attacker;
            pmove_r <= p_move;
          end
        end
        ST_SELECT:  sel_r  <= att_r ? lfsr_q_s[1:0] : pmove_r;
        ST_ROLL:    roll_r <= lfsr_q_s[3:0];
        ST_RESOLVE: begin
          move_used_r <= sel_r;
          hit_r       <= hit_s;
          dmg_r       <= dmg_s;
        end
        default: ;
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign move_used = move_used_r;
  assign hit       = hit_r;
  assign dmg       = dmg_r;

endmodule

// File: tb/tb_move_resolver.sv
// Self-checking bench for move_resolver: attack-level reference model plus directed literal checks.
module tb_move_resolver;

  logic       clk = 1'b0;
  logic       reset_n, start, attacker;
  logic [1:0] p_move;
  logic       busy, done, hit, crit;
  logic [1:0] move_used;
  logic [3:0] dmg;

  int n_tests = 0;
  int n_fail  = 0;

  move_resolver u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .attacker(attacker), .p_move(p_move),
    .busy(busy), .done(done), .move_used(move_used), .hit(hit), .dmg(dmg), .crit(crit)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one attack at a time) ----------------
  int acc_t [4] = '{15, 11, 7, 3};
  int dmg_t [4] = '{2, 4, 6, 9};

  function automatic logic [7:0] lstep(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [7:0] m_lfsr;
  logic       m_valid = 1'b0;
  logic       m_busy, m_done, m_hit, m_crit;
  logic [1:0] m_move, m_ai_sel;
  logic [3:0] m_dmg;
  int         m_cnt;
  logic       p_hit, p_crit;
  logic [1:0] p_move_res;
  logic [3:0] p_dmg;

  always @(posedge clk) begin
    logic [7:0] s1, s2;
    int d;
    if (!reset_n) begin
      m_lfsr = 8'hA5; m_busy = 1'b0; m_done = 1'b0; m_move = 2'd0;
      m_hit = 1'b0; m_dmg = 4'd0; m_crit = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0 && start) begin
        // LFSR value one cycle later selects the AI move, two cycles later gives the rolls.
        s1 = lstep(m_lfsr);
        s2 = lstep(s1);
        m_ai_sel   = s1[1:0];
        p_move_res = attacker ? s1[1:0] : p_move;
        p_hit      = (int'(s2[3:0]) <= acc_t[p_move_res]);
        d          = p_hit ? dmg_t[p_move_res] : 0;
        p_crit     = 1'b0;
`ifdef CRIT_HIT_EN
        p_crit = p_hit && (s2[7:4] == 4'hF);
        if (p_crit) d = (2 * d > 15) ? 15 : 2 * d;
`endif
        p_dmg  = 4'(d);
        m_cnt  = 4;
        m_busy = 1'b1;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 1) begin
          m_done = 1'b1; m_move = p_move_res; m_hit = p_hit; m_dmg = p_dmg; m_crit = p_crit;
        end
        if (m_cnt == 0) m_busy = 1'b0;
      end
      m_lfsr = lstep(m_lfsr);
    end
    m_valid = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {7'd0, busy}, {7'd0, m_busy});
      chk("done", {7'd0, done}, {7'd0, m_done});
      chk("move_used", {6'd0, move_used}, {6'd0, m_move});
      chk("hit", {7'd0, hit}, {7'd0, m_hit});
      chk("dmg", {4'd0, dmg}, {4'd0, m_dmg});
      chk("crit", {7'd0, crit}, {7'd0, m_crit});
      chk("lfsr", u_dut.lfsr_q_s, m_lfsr);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic attack(input logic att, input logic [1:0] pm, output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    start = 1'b1; attacker = att; p_move = pm;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done && !seen) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 8'd0, 8'd1);
    @(negedge clk);
  endtask

  initial begin
    int lat, hits, pulses, first_i, second_i;
    logic ok;
    reset_n = 1'b0; start = 1'b0; attacker = 1'b0; p_move = 2'd0;
    repeat (2) @(negedge clk);

    // Reset values and the first LFSR steps out of reset.
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_dmg", {4'd0, dmg}, 8'd0);
    chk("rst_hit", {7'd0, hit}, 8'd0);
    chk("rst_crit", {7'd0, crit}, 8'd0);
    chk("rst_lfsr", u_dut.lfsr_q_s, 8'hA5);
    reset_n = 1'b1;
    @(negedge clk);
    chk("lfsr_step1", u_dut.lfsr_q_s, 8'h4A);
    @(negedge clk);
    chk("lfsr_step2", u_dut.lfsr_q_s, 8'h95);

    // Move 0 always hits.
    attack(1'b0, 2'd0, lat);
    chk("hit0_latency", 8'(lat), 8'd4);
    chk("hit0_move", {6'd0, move_used}, 8'd0);
    chk("hit0_hit", {7'd0, hit}, 8'd1);
`ifdef CRIT_HIT_EN
    chk("hit0_dmg", {4'd0, dmg}, crit ? 8'd4 : 8'd2);
`else
    chk("hit0_dmg", {4'd0, dmg}, 8'd2);
`endif

    // AI attacks ignore the player move.
    for (int k = 0; k < 4; k++) begin
      attack(1'b1, 2'd2, lat);
      chk("ai_move", {6'd0, move_used}, {6'd0, m_ai_sel});
      chk("ai_latency", 8'(lat), 8'd4);
    end

    // Start held high: one accept, the DONE-cycle start ignored, the next cycle accepted.
    pulses = 0; first_i = -1; second_i = -1;
    start = 1'b1; attacker = 1'b0; p_move = 2'd1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 10) start = 1'b0;
      if (done) begin
        pulses++;
        if (first_i < 0) first_i = i;
        else if (second_i < 0) second_i = i;
      end
    end
    chk("busy_pulses", 8'(pulses), 8'd2);
    chk("busy_first", 8'(first_i), 8'd4);
    chk("busy_second", 8'(second_i), 8'd9);

    // Reset sampled at the end of ROLL aborts the attack.
    pulses = 0;
    start = 1'b1; attacker = 1'b0; p_move = 2'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 2) reset_n = 1'b0;
      if (i == 3) begin
        reset_n = 1'b1;
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_move", {6'd0, move_used}, 8'd0);
        chk("abort_hit", {7'd0, hit}, 8'd0);
        chk("abort_dmg", {4'd0, dmg}, 8'd0);
      end
      if (done) pulses++;
    end
    chk("abort_no_done", 8'(pulses), 8'd0);
    attack(1'b0, 2'd0, lat);
    chk("abort_recover_latency", 8'(lat), 8'd4);

    // Sweep of move 3 with irregular gaps so the rolls cover the whole LFSR cycle.
    hits = 0;
    for (int n = 0; n < 1000; n++) begin
      attack(1'b0, 2'd3, lat);
      ok = (dmg == 4'd0) || (dmg == 4'd9);
`ifdef CRIT_HIT_EN
      ok = ok || (dmg == 4'd15);
`endif
      chk("sweep_dmg_set", {7'd0, ok}, 8'd1);
      if (hit) hits++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    chk("sweep_hit_rate", {7'd0, (hits >= 180 && hits <= 320)}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
